alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Multi-cycle ALU execute stage; consumes the 4-bit alu_ctrl code produced by the ALU control decoder, plus two operands.
- Single-cycle ops, iterative shifter and optional iterative multiplier behind a valid/ready handshake on both sides.
- Sits between decode/regfile read and writeback; returns a registered result and a zero flag (BEQ compare uses SUB then zero).

Parameters:
- XLEN, 32, operand/result width (power of 2, >= 8)
- SHW, $clog2(XLEN), shift-amount width; derived, not overridden

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request
- alu_ctrl  in  4  operation code
- op_a  in  XLEN  operand A
- op_b  in  XLEN  operand B (low SHW bits = shift amount for shifts)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  XLEN  operation result
- zero  out  1  result == 0
- illegal  out  1  alu_ctrl was not a supported code

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 MUL (low XLEN bits). All others are illegal.
- FSM states IDLE, BUSY, DONE.
- IDLE: in_ready=1.
  - Transfer occurs when in_valid && in_ready; operands and code are latched.
  - Single-cycle or illegal op -> DONE next cycle (latency 1).
  - Shift with shamt=0 -> DONE with result=op_a.
  - Shift with shamt=n>0 -> BUSY, shifting one bit per cycle for n cycles (latency n+1).
  - MUL -> BUSY for XLEN shift-add cycles (latency XLEN+1).
- BUSY: in_ready=0, out_valid=0; iterates, then -> DONE.
- DONE: out_valid=1.
  - result, zero and illegal are held stable until out_ready.
  - On out_ready -> IDLE.
  - No new request is accepted in the same cycle (in_ready=0 in DONE).
- Arithmetic:
  - ADD/SUB/MUL wrap modulo 2^XLEN; no overflow flag.
  - SLT/SLTU produce 0 or 1, zero-extended.
  - SRA replicates the sign bit each step.
- Illegal code: result=0, zero=1, illegal=1, latency 1.
- Inputs are ignored while in_ready=0; op_a/op_b/alu_ctrl are only sampled at transfer.
- Reset values: state=IDLE, in_ready=1 after reset, out_valid=0, result=0, zero=0, illegal=0.
- Reset mid-BUSY or mid-DONE: operation is abandoned, no output is produced, and the unit returns to IDLE next cycle.
- out_ready asserted outside DONE has no effect.

Optional Feature:
- Macro ALU_EXEC_MUL_EN.
- Defined: code 1010 performs the iterative multiply described above; the multiplier datapath (accumulator, multiplicand, counter) is compiled in.
- Undefined: no multiplier logic; 1010 is treated as illegal (result=0, zero=1, illegal=1, latency 1).

Decomposition:
- Package alu_pkg holds:
  - the alu_ctrl encoding constants (ALU_ADD..ALU_MUL), shared with the ALU control decoder;
  - the FSM state typedef;
  - XLEN default.
- One sub-module is natural: alu_iter_shifter (latched value, remaining count, direction/arith mode, done pulse).
- The multiplier stays inline under the macro.

Test Plan:
- ADD 5+7 (XLEN=32) -> out_valid 1 cycle after transfer, result=12, zero=0; SUB 9-9 -> result=0, zero=1.
- SLT 0xFFFFFFFF vs 1 -> result=1; SLTU same operands -> result=0.
- SRA 0x80000000 by 4 -> result=0xF8000000, out_valid exactly 5 cycles after transfer, in_ready=0 throughout; SLL by 0 -> result=op_a in 1 cycle.
- Backpressure: out_ready held low 3 cycles in DONE -> result/zero stable, in_ready=0; out_ready high -> IDLE, new request accepted next cycle.
- MUL 0x10000 x 0x10001 with ALU_EXEC_MUL_EN -> result=0x00010000 after 33 cycles; without the macro -> illegal=1, result=0 after 1 cycle; code 1111 -> illegal=1 either way.
- rst_n low for 1 cycle during BUSY of SRL by 20 -> out_valid never rises for that op, in_ready=1 the cycle after reset releases.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: alu_ctrl encodings (also used
// by the ALU control decoder), FSM state type, shifter mode type and default
// datapath width.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10
    } shift_mode_e;

    function automatic logic is_shift_op(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_iter_shifter.sv
// Iterative one-bit-per-cycle shifter. Holds the value being shifted, the
// remaining step count and the direction/arithmetic mode. result_o is the
// value after the current step; done_o flags the final step so the caller
// can capture result_o on that same edge.
module alu_iter_shifter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  shift_mode_e     mode_i,
    input  logic [XLEN-1:0] value_i,
    input  logic [SHW-1:0]  shamt_i,
    output logic [XLEN-1:0] result_o,
    output logic            done_o
);

    logic [XLEN-1:0] value_q, value_d, step_s;
    logic [SHW-1:0]  count_q, count_d;
    shift_mode_e     mode_q, mode_d;

    // One-bit step of the held value in the latched direction
    always_comb begin
        step_s = value_q;
        case (mode_q)
            SH_SLL:  step_s = {value_q[XLEN-2:0], 1'b0};
            SH_SRL:  step_s = {1'b0, value_q[XLEN-1:1]};
            SH_SRA:  step_s = {value_q[XLEN-1], value_q[XLEN-1:1]};
            default: step_s = value_q;
        endcase
    end

    // Next state: load a new job, take one step, or hold
    always_comb begin
        value_d = value_q;
        count_d = count_q;
        mode_d  = mode_q;
        if (start_i) begin
            value_d = value_i;
            count_d = shamt_i;
            mode_d  = mode_i;
        end else if (count_q != '0) begin
            value_d = step_s;
            count_d = count_q - SHW'(1);
        end else begin
            value_d = value_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= '0;
            count_q <= '0;
            mode_q  <= SH_SLL;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
            mode_q  <= mode_d;
        end
    end

    assign result_o = step_s;
    assign done_o   = (count_q == SHW'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage with valid/ready handshake on both sides.
// Single-cycle logic/arith ops, iterative shifter, and an optional iterative
// shift-add multiplier enabled by defining ALU_EXEC_MUL_EN. Without the macro,
// code ALU_MUL is reported as illegal.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    logic [XLEN-1:0] single_res_s;
    logic            single_legal_s;
    logic [SHW-1:0]  shamt_s;
    shift_mode_e     shift_mode_s;
    logic            shift_start_s;
    logic [XLEN-1:0] shift_res_s;
    logic            shift_done_s;

`ifdef ALU_EXEC_MUL_EN
    logic            busy_mul_q, busy_mul_d;
    logic            mul_load_s;
    logic [XLEN-1:0] mul_acc_q, mul_acc_d, mul_acc_nxt_s;
    logic [XLEN-1:0] mul_mcand_q, mul_mcand_d;
    logic [XLEN-1:0] mul_mplier_q, mul_mplier_d;
    logic [SHW:0]    mul_cnt_q, mul_cnt_d;
`endif

    assign shamt_s = op_b[SHW-1:0];

    // Single-cycle operation results; non-single codes flagged not legal here
    always_comb begin
        single_res_s   = '0;
        single_legal_s = 1'b1;
        case (alu_ctrl)
            ALU_ADD:  single_res_s = op_a + op_b;
            ALU_SUB:  single_res_s = op_a - op_b;
            ALU_AND:  single_res_s = op_a & op_b;
            ALU_OR:   single_res_s = op_a | op_b;
            ALU_XOR:  single_res_s = op_a ^ op_b;
            ALU_SLT:  single_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: single_res_s = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default: begin
                single_res_s   = '0;
                single_legal_s = 1'b0;
            end
        endcase
    end

    // Map the shift opcode onto the shifter mode
    always_comb begin
        shift_mode_s = SH_SLL;
        case (alu_ctrl)
            ALU_SRL: shift_mode_s = SH_SRL;
            ALU_SRA: shift_mode_s = SH_SRA;
            default: shift_mode_s = SH_SLL;
        endcase
    end

    alu_iter_shifter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (shift_start_s),
        .mode_i   (shift_mode_s),
        .value_i  (op_a),
        .shamt_i  (shamt_s),
        .result_o (shift_res_s),
        .done_o   (shift_done_s)
    );

`ifdef ALU_EXEC_MUL_EN
    // Shift-add multiplier: one multiplier bit per BUSY cycle
    always_comb begin
        mul_acc_nxt_s = mul_mplier_q[0] ? (mul_acc_q + mul_mcand_q) : mul_acc_q;
        mul_acc_d     = mul_acc_q;
        mul_mcand_d   = mul_mcand_q;
        mul_mplier_d  = mul_mplier_q;
        mul_cnt_d     = mul_cnt_q;
        if (mul_load_s) begin
            mul_acc_d    = '0;
            mul_mcand_d  = op_a;
            mul_mplier_d = op_b;
            mul_cnt_d    = (SHW+1)'(XLEN);
        end else if ((state_q == ST_BUSY) && busy_mul_q && (mul_cnt_q != '0)) begin
            mul_acc_d    = mul_acc_nxt_s;
            mul_mcand_d  = {mul_mcand_q[XLEN-2:0], 1'b0};
            mul_mplier_d = {1'b0, mul_mplier_q[XLEN-1:1]};
            mul_cnt_d    = mul_cnt_q - (SHW+1)'(1);
        end else begin
            mul_cnt_d = mul_cnt_q;
        end
    end
`endif

    // FSM next state and output-register updates
    always_comb begin
        state_d       = state_q;
        result_d      = result_q;
        zero_d        = zero_q;
        illegal_d     = illegal_q;
        shift_start_s = 1'b0;
`ifdef ALU_EXEC_MUL_EN
        mul_load_s    = 1'b0;
        busy_mul_d    = busy_mul_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_shift_op(alu_ctrl)) begin
                        if (shamt_s == '0) begin
                            result_d  = op_a;
                            zero_d    = (op_a == '0);
                            illegal_d = 1'b0;
                            state_d   = ST_DONE;
                        end else begin
                            shift_start_s = 1'b1;
                            state_d       = ST_BUSY;
`ifdef ALU_EXEC_MUL_EN
                            busy_mul_d    = 1'b0;
`endif
                        end
                    end
`ifdef ALU_EXEC_MUL_EN
                    else if (alu_ctrl == ALU_MUL) begin
                        mul_load_s = 1'b1;
                        busy_mul_d = 1'b1;
                        state_d    = ST_BUSY;
                    end
`endif
                    else if (single_legal_s) begin
                        result_d  = single_res_s;
                        zero_d    = (single_res_s == '0);
                        illegal_d = 1'b0;
                        state_d   = ST_DONE;
                    end else begin
                        result_d  = '0;
                        zero_d    = 1'b1;
                        illegal_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
`ifdef ALU_EXEC_MUL_EN
                if (busy_mul_q) begin
                    if (mul_cnt_q == (SHW+1)'(1)) begin
                        result_d  = mul_acc_nxt_s;
                        zero_d    = (mul_acc_nxt_s == '0);
                        illegal_d = 1'b0;
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end else
`endif
                if (shift_done_s) begin
                    result_d  = shift_res_s;
                    zero_d    = (shift_res_s == '0);
                    illegal_d = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            result_q     <= '0;
            zero_q       <= 1'b0;
            illegal_q    <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            busy_mul_q   <= 1'b0;
            mul_acc_q    <= '0;
            mul_mcand_q  <= '0;
            mul_mplier_q <= '0;
            mul_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            illegal_q    <= illegal_d;
`ifdef ALU_EXEC_MUL_EN
            busy_mul_q   <= busy_mul_d;
            mul_acc_q    <= mul_acc_d;
            mul_mcand_q  <= mul_mcand_d;
            mul_mplier_q <= mul_mplier_d;
            mul_cnt_q    <= mul_cnt_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized
// operations compared against an arithmetic reference model. Follows the
// ALU_EXEC_MUL_EN build option for the expected MUL behaviour.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int XLEN = 32;
`ifdef ALU_EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    // Reference model: plain arithmetic from the opcode table
    function automatic logic [31:0] model_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (c)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << sh;
            4'd8:  return a >> sh;
            4'd9:  return 32'($signed(a) >>> sh);
            4'd10: return MUL_EN ? 32'(a * b) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_ill(input logic [3:0] c);
        return !((c <= 4'd9) || ((c == 4'd10) && MUL_EN));
    endfunction

    function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
        if (c == 4'd7 || c == 4'd8 || c == 4'd9)
            return (b[4:0] == 5'd0) ? 1 : int'(b[4:0]) + 1;
        if (c == 4'd10 && MUL_EN)
            return 33;
        return 1;
    endfunction

    // Issue one request and wait (bounded) for out_valid; leaves the unit in DONE
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic z, output logic ill,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom); op_a = $urandom; op_b = $urandom;
        lat = 1; busy_ok = 1'b1;
        while (!out_valid && lat < 200) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        r = result; z = zero; ill = illegal;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctrl = 4'd0; op_a = 32'd0; op_b = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        checks++; if ({zero, illegal} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {zero, illegal}); end
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL idle_out_ready got %b want 10", {in_ready, out_valid}); end
    endtask

    task automatic test_single();
        logic [31:0] r; logic z, ill; int lat; bit bok;
        run_op(ALU_ADD, 32'd5, 32'd7, r, z, ill, lat, bok);
        checks++; if (r !== 32'd12 || z !== 1'b0 || ill !== 1'b0) begin errors++; $display("FAIL add got %h z%b i%b want 0000000c z0 i0", r, z, ill); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
        drain();
        run_op(ALU_SUB, 32'd9, 32'd9, r, z, ill, lat, bok);
        checks++; if (r !== 32'd0 || z !== 1'b1) begin errors++; $display("FAIL sub_zero got %h z%b want 0 z1", r, z); end
        drain();
        run_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1, r, z, ill, lat, bok);
        checks++; if (r !== 32'd1) begin errors++; $display("FAIL slt got %h want 1", r); end
        drain();
        run_op(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, r, z, ill, lat, bok);
        checks++; if (r !== 32'd0 || z !== 1'b1) begin errors++; $display("FAIL sltu got %h z%b want 0 z1", r, z); end
        drain();
    endtask

    task automatic test_shift();
        logic [31:0] r; logic z, ill; int lat; bit bok;
        run_op(ALU_SRA, 32'h8000_0000, 32'd4, r, z, ill, lat, bok);
        checks++; if (r !== 32'hF800_0000) begin errors++; $display("FAIL sra got %h want f8000000", r); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL sra_latency got %0d want 5", lat); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL sra_busy_in_ready got %b want 1", bok); end
        drain();
        run_op(ALU_SLL, 32'h1234_5678, 32'h0000_0020, r, z, ill, lat, bok);
        checks++; if (r !== 32'h1234_5678 || lat !== 1) begin errors++; $display("FAIL sll0 got %h lat %0d want 12345678 lat 1", r, lat); end
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] r; logic z, ill; int lat; bit bok;
        run_op(ALU_ADD, 32'd3, 32'd4, r, z, ill, lat, bok);
        in_valid = 1'b1; alu_ctrl = ALU_SUB; op_a = 32'd1; op_b = 32'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (result !== 32'd7 || zero !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d got %h z%b v%b r%b want 00000007 z0 v1 r0", i, result, zero, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL release got %b want 10", {in_ready, out_valid}); end
        run_op(ALU_XOR, 32'hF0F0_0000, 32'h0FF0_0001, r, z, ill, lat, bok);
        checks++; if (r !== 32'hFF00_0001 || lat !== 1) begin errors++; $display("FAIL after_release got %h lat %0d want ff000001 lat 1", r, lat); end
        drain();
    endtask

    task automatic test_mul_illegal();
        logic [31:0] r; logic z, ill; int lat; bit bok;
        run_op(ALU_MUL, 32'h0001_0000, 32'h0001_0001, r, z, ill, lat, bok);
        checks++;
        if (r !== (MUL_EN ? 32'h0001_0000 : 32'd0) || ill !== !MUL_EN || lat !== (MUL_EN ? 33 : 1)) begin
            errors++;
            $display("FAIL mul got %h i%b lat %0d want %h i%b lat %0d", r, ill, lat,
                     MUL_EN ? 32'h0001_0000 : 32'd0, !MUL_EN, MUL_EN ? 33 : 1);
        end
        drain();
        run_op(4'b1111, 32'h1234, 32'h5678, r, z, ill, lat, bok);
        checks++; if (r !== 32'd0 || z !== 1'b1 || ill !== 1'b1 || lat !== 1) begin errors++; $display("FAIL illegal got %h z%b i%b lat %0d want 0 z1 i1 lat 1", r, z, ill, lat); end
        drain();
    endtask

    task automatic test_reset_busy();
        int rises;
        @(negedge clk);
        alu_ctrl = ALU_SRL; op_a = 32'hFFFF_0000; op_b = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_before_reset got %b want 0", in_ready); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL after_reset got %b want 10", {in_ready, out_valid}); end
        rises = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) rises++;
        end
        checks++; if (rises !== 0) begin errors++; $display("FAIL abandoned_op got %0d valid cycles want 0", rises); end
    endtask

    task automatic test_random();
        logic [31:0] r, a, b, er; logic z, ill; int lat, el; bit bok;
        logic [3:0] c;
        for (int n = 0; n < 60; n++) begin
            c = (n % 8 == 7) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            a = $urandom; b = $urandom;
            if (n % 5 == 0) b = a;
            er = model_res(c, a, b);
            el = model_lat(c, b);
            run_op(c, a, b, r, z, ill, lat, bok);
            checks++;
            if (r !== er || z !== (er == 32'd0) || ill !== model_ill(c) || lat !== el || bok !== 1'b1) begin
                errors++;
                $display("FAIL rand_%0d op %0d a %h b %h got %h z%b i%b lat %0d want %h z%b i%b lat %0d",
                         n, c, a, b, r, z, ill, lat, er, (er == 32'd0), model_ill(c), el);
            end
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_shift();
        test_backpressure();
        test_mul_illegal();
        test_reset_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
